ucaspian_step_ctrl: RTL and testbench

Timestep sequencer for the uCaspian core (axon, synapse, neuron units). Accepts host commands (clear activity, clear configuration, run N steps) and drives the shared clear_act / clear_config / next_step / enable controls. Aggregates per-unit clear_done / step_done into command completion and a global time counter.

---
 rtl/ucaspian_step_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ucaspian_step_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_step_ctrl.sv
// Timestep sequencer for uCaspian: host clear/run commands -> clear/next_step/enable, done aggregation, time counter.
// Outputs registered (1 cycle); cmd_ready only in IDLE, host holds cmd_valid. Optional watchdog: UCASPIAN_STEP_WATCHDOG_EN.
module ucaspian_step_ctrl #(
    parameter int NUM_UNITS     = 3,
    parameter int TIME_W        = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int WDOG_CYCLES   = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [15:0]          cmd_steps,
    input  logic                 cmd_abort,
    output logic                 clear_act,
    output logic                 clear_config,
    output logic                 next_step,
    output logic                 enable,
    input  logic [NUM_UNITS-1:0] clear_done,
    input  logic [NUM_UNITS-1:0] step_done,
    output logic                 busy,
    output logic                 step_tick,
    output logic [TIME_W-1:0]    time_count,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_SETTLE,
        S_WAIT_DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t              state, state_d;
    logic [15:0]         remaining, remaining_d;
    logic [3:0]          settle_cnt, settle_d;
    logic                cfg_sel, cfg_sel_d;
    logic [TIME_W-1:0]   time_d;
    logic                tick_d;
    logic                err_d;

`ifdef UCASPIAN_STEP_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_cnt, wdog_d;
    logic              wdog_run;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        settle_d    = settle_cnt;
        cfg_sel_d   = cfg_sel;
        time_d      = time_count;
        tick_d      = 1'b0;
        err_d       = err;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        2'd1: begin
                            state_d   = S_CLEAR;
                            cfg_sel_d = 1'b0;
                            settle_d  = SETTLE_INIT;
                        end
                        2'd2: begin
                            state_d   = S_CLEAR;
                            cfg_sel_d = 1'b1;
                            settle_d  = SETTLE_INIT;
                        end
                        2'd3: begin
                            if (cmd_steps != 16'd0) begin
                                remaining_d = cmd_steps;
                                state_d     = S_STEP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CLEAR: begin
                // Units may still report done from a previous clear; ignore until settled.
                if (settle_cnt != 4'd0) begin
                    settle_d = settle_cnt - 4'd1;
                end else if (&clear_done) begin
                    time_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (remaining != 16'd0) remaining_d = remaining - 16'd1;
                settle_d = SETTLE_INIT;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    settle_d = 4'd0;
                    state_d  = S_WAIT_DONE;
                end else begin
                    settle_d = settle_cnt - 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (&step_done) begin
                    tick_d = 1'b1;
                    time_d = time_count + TIME_W'(1);
                    if (remaining == 16'd0 || cmd_abort) state_d = S_IDLE;
                    else                                state_d = S_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef UCASPIAN_STEP_WATCHDOG_EN
        // A stalled unit must not hang the host forever; give up and flag it.
        wdog_run = ((state == S_CLEAR) && (settle_cnt == 4'd0)) || (state == S_WAIT_DONE);
        if (wdog_run && (state_d == state) && (wdog_cnt == WDOG_LAST)) begin
            err_d       = 1'b1;
            state_d     = S_IDLE;
            remaining_d = 16'd0;
        end
        if (state_d != state) wdog_d = '0;
        else if (wdog_run)    wdog_d = wdog_cnt + WDOG_W'(1);
        else                  wdog_d = wdog_cnt;
`endif
    end

`ifdef UCASPIAN_STEP_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) wdog_cnt <= '0;
        else       wdog_cnt <= wdog_d;
    end
`endif

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= 16'd0;
            settle_cnt   <= 4'd0;
            cfg_sel      <= 1'b0;
            time_count   <= '0;
            step_tick    <= 1'b0;
            err          <= 1'b0;
            clear_act    <= 1'b0;
            clear_config <= 1'b0;
            next_step    <= 1'b0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b0;
        end else begin
            state        <= state_d;
            remaining    <= remaining_d;
            settle_cnt   <= settle_d;
            cfg_sel      <= cfg_sel_d;
            time_count   <= time_d;
            step_tick    <= tick_d;
            err          <= err_d;
            clear_act    <= (state_d == S_CLEAR) && !cfg_sel_d;
            clear_config <= (state_d == S_CLEAR) && cfg_sel_d;
            next_step    <= (state_d == S_STEP);
            enable       <= (state_d == S_STEP) || (state_d == S_SETTLE) || (state_d == S_WAIT_DONE);
            busy         <= (state_d != S_IDLE);
            cmd_ready    <= (state_d == S_IDLE);
        end
    end

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Bench for ucaspian_step_ctrl: scoreboard of expected time_count per step_tick plus per-scenario checks.
module tb_ucaspian_step_ctrl;
    localparam int NU = 3;
    localparam int TW = 32;
    localparam int SC = 2;
    localparam int WD = 16;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [15:0]   cmd_steps;
    logic          cmd_abort;
    logic          clear_act;
    logic          clear_config;
    logic          next_step;
    logic          enable;
    logic [NU-1:0] clear_done;
    logic [NU-1:0] step_done;
    logic          busy;
    logic          step_tick;
    logic [TW-1:0] time_count;
    logic          err;

    int            tests = 0;
    int            fails = 0;
    int            ns_count = 0;
    int            tick_count = 0;
    int            resp_mode = 0;
    int            resp_d = 0;
    logic [TW-1:0] model_time = '0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] exp_v;

    ucaspian_step_ctrl #(
        .NUM_UNITS(NU), .TIME_W(TW), .SETTLE_CYCLES(SC), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_abort(cmd_abort),
        .clear_act(clear_act), .clear_config(clear_config), .next_step(next_step),
        .enable(enable), .clear_done(clear_done), .step_done(step_done), .busy(busy),
        .step_tick(step_tick), .time_count(time_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit model: mode 0 = done rises 5 cycles after next_step, 1 = stuck high, 2 = unit 1 never done.
    initial begin
        step_done = '1;
        forever begin
            @(posedge clk);
            #1;
            case (resp_mode)
                1: step_done = '1;
                2: step_done = 3'b101;
                default: begin
                    if (next_step) begin
                        step_done = '0;
                        resp_d = 5;
                    end else if (resp_d > 1) begin
                        resp_d--;
                    end else begin
                        resp_d = 0;
                        step_done = '1;
                    end
                end
            endcase
        end
    end

    // Scoreboard: every step_tick must match the next queued time_count.
    always @(negedge clk) begin
        if (!reset) begin
            if (next_step) ns_count++;
            if (next_step && (clear_act || clear_config)) begin
                tests++; fails++;
                $display("FAIL overlap: next_step with clear high");
            end
            if (step_tick) begin
                tick_count++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL tick_unexpected: time_count=%0d, no tick expected", time_count);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (time_count !== exp_v) begin
                        fails++;
                        $display("FAIL tick_time: got %0d expected %0d", time_count, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] steps);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_steps = steps;
        for (int i = 0; i < 50; i++) begin
            acc = cmd_ready;
            cyc();
            if (acc) break;
        end
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_steps = 16'd0;
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL cmd_accept: got %0b expected 1", acc); end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            cyc();
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL idle_timeout: busy=%0b expected 0", busy); end
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        tests++;
        if ({busy, enable, next_step, clear_act, clear_config, step_tick, err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {busy, enable, next_step, clear_act, clear_config, step_tick, err});
        end
        tests++;
        if (time_count !== '0) begin fails++; $display("FAIL reset_time: got %0d expected 0", time_count); end
        reset = 1'b0;
        cyc();
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
    endtask

    task automatic test_clear(input logic [1:0] op);
        int hi, edges, other, en;
        logic prev, sel, oth;
        hi = 0; edges = 0; other = 0; en = 0; prev = 1'b0;
        send_cmd(op, 16'd0);
        for (int i = 0; i < 40; i++) begin
            sel = (op == 2'd1) ? clear_act : clear_config;
            oth = (op == 2'd1) ? clear_config : clear_act;
            if (sel) hi++;
            if (sel && !prev) edges++;
            prev = sel;
            if (oth) other++;
            if (enable) en++;
            if (!busy) break;
            cyc();
        end
        model_time = '0;
        tests++;
        if (hi < SC + 1) begin fails++; $display("FAIL clear_len op%0d: got %0d expected >=%0d", op, hi, SC + 1); end
        tests++;
        if (edges != 1) begin fails++; $display("FAIL clear_intervals op%0d: got %0d expected 1", op, edges); end
        tests++;
        if (other != 0 || en != 0) begin
            fails++; $display("FAIL clear_other op%0d: other=%0d enable=%0d expected 0", op, other, en);
        end
        tests++;
        if (busy !== 1'b0 || time_count !== '0) begin
            fails++; $display("FAIL clear_end op%0d: busy=%0b time=%0d expected 0/0", op, busy, time_count);
        end
        cyc();
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL clear_ready: got %0b expected 1", cmd_ready); end
    endtask

    task automatic test_run3();
        int ns0, tk0;
        resp_mode = 0;
        ns0 = ns_count; tk0 = tick_count;
        for (int k = 1; k <= 3; k++) exp_q.push_back(model_time + TW'(k));
        model_time = model_time + TW'(3);
        send_cmd(2'd3, 16'd3);
        wait_idle(200);
        tests++;
        if (ns_count - ns0 != 3) begin fails++; $display("FAIL run3_next_step: got %0d expected 3", ns_count - ns0); end
        tests++;
        if (tick_count - tk0 != 3) begin fails++; $display("FAIL run3_ticks: got %0d expected 3", tick_count - tk0); end
        tests++;
        if (time_count !== model_time) begin fails++; $display("FAIL run3_time: got %0d expected %0d", time_count, model_time); end
        tests++;
        if (cmd_ready !== 1'b1 || enable !== 1'b0) begin
            fails++; $display("FAIL run3_idle: ready=%0b enable=%0b expected 1/0", cmd_ready, enable);
        end
    endtask

    task automatic test_run0();
        int ns0, busy_seen;
        ns0 = ns_count; busy_seen = 0;
        send_cmd(2'd3, 16'd0);
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_seen++;
            cyc();
        end
        tests++;
        if (ns_count != ns0 || busy_seen != 0) begin
            fails++; $display("FAIL run0: next_step=%0d busy_cycles=%0d expected 0/0", ns_count - ns0, busy_seen);
        end
        tests++;
        if (time_count !== model_time) begin fails++; $display("FAIL run0_time: got %0d expected %0d", time_count, model_time); end
    endtask

    task automatic test_abort();
        int ns0, tk0;
        cmd_abort = 1'b1;
        repeat (3) cyc();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: busy=%0b expected 0", busy); end
        cmd_abort = 1'b0;
        test_clear(2'd1);
        resp_mode = 0;
        ns0 = ns_count; tk0 = tick_count;
        for (int k = 1; k <= 4; k++) exp_q.push_back(model_time + TW'(k));
        model_time = model_time + TW'(4);
        send_cmd(2'd3, 16'd10);
        for (int i = 0; i < 300; i++) begin
            if (ns_count - ns0 >= 4) break;
            cyc();
        end
        cmd_abort = 1'b1;
        wait_idle(100);
        cmd_abort = 1'b0;
        repeat (10) cyc();
        tests++;
        if (ns_count - ns0 != 4) begin fails++; $display("FAIL abort_next_step: got %0d expected 4", ns_count - ns0); end
        tests++;
        if (tick_count - tk0 != 4) begin fails++; $display("FAIL abort_ticks: got %0d expected 4", tick_count - tk0); end
        tests++;
        if (time_count !== TW'(4)) begin fails++; $display("FAIL abort_time: got %0d expected 4", time_count); end
    endtask

    task automatic test_stuck_done();
        int ns_cyc[$];
        int tk_cyc[$];
        resp_mode = 1;
        for (int k = 1; k <= 3; k++) exp_q.push_back(model_time + TW'(k));
        model_time = model_time + TW'(3);
        send_cmd(2'd3, 16'd3);
        for (int c = 0; c < 60; c++) begin
            if (next_step) ns_cyc.push_back(c);
            if (step_tick) tk_cyc.push_back(c);
            if (!busy) break;
            cyc();
        end
        wait_idle(10);
        tests++;
        if (ns_cyc.size() != 3 || tk_cyc.size() != 3) begin
            fails++; $display("FAIL stuck_counts: next_step=%0d ticks=%0d expected 3/3", ns_cyc.size(), tk_cyc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (ns_cyc[i+1] - ns_cyc[i] != SC + 2) begin
                    fails++; $display("FAIL stuck_period%0d: got %0d expected %0d", i, ns_cyc[i+1] - ns_cyc[i], SC + 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (tk_cyc[i] - ns_cyc[i] < SC + 1) begin
                    fails++; $display("FAIL stuck_settle%0d: got %0d expected >=%0d", i, tk_cyc[i] - ns_cyc[i], SC + 1);
                end
            end
        end
        tests++;
        if (time_count !== model_time) begin fails++; $display("FAIL stuck_time: got %0d expected %0d", time_count, model_time); end
    endtask

    task automatic test_watchdog();
        int tk0;
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_pre: got %0b expected 0", err); end
        resp_mode = 2;
        tk0 = tick_count;
        send_cmd(2'd3, 16'd1);
`ifdef UCASPIAN_STEP_WATCHDOG_EN
        begin
            int c;
            c = 0;
            while (c < 60 && busy) begin
                cyc();
                c++;
            end
            tests++;
            if (c != SC + WD + 1) begin fails++; $display("FAIL wdog_time: got %0d expected %0d", c, SC + WD + 1); end
            tests++;
            if (err !== 1'b1 || enable !== 1'b0) begin
                fails++; $display("FAIL wdog_err: err=%0b enable=%0b expected 1/0", err, enable);
            end
            cyc();
            tests++;
            if (cmd_ready !== 1'b1 || tick_count != tk0) begin
                fails++; $display("FAIL wdog_idle: ready=%0b ticks=%0d expected 1/0", cmd_ready, tick_count - tk0);
            end
            resp_mode = 0;
        end
`else
        repeat (40) cyc();
        tests++;
        if (busy !== 1'b1 || enable !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL nowdog_wait: busy=%0b enable=%0b err=%0b expected 1/1/0", busy, enable, err);
        end
        tests++;
        if (tick_count != tk0) begin fails++; $display("FAIL nowdog_tick: got %0d expected 0", tick_count - tk0); end
        exp_q.push_back(model_time + TW'(1));
        model_time = model_time + TW'(1);
        resp_mode = 0;
        wait_idle(50);
        tests++;
        if (tick_count - tk0 != 1 || time_count !== model_time) begin
            fails++; $display("FAIL nowdog_release: ticks=%0d time=%0d expected 1/%0d", tick_count - tk0, time_count, model_time);
        end
`endif
    endtask

    task automatic test_reset_mid();
        resp_mode = 0;
        send_cmd(2'd3, 16'd10);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        tests++;
        if ({busy, enable, next_step, step_tick, err} !== 5'b0 || time_count !== '0) begin
            fails++; $display("FAIL reset_mid: flags=%b time=%0d expected 00000/0",
                              {busy, enable, next_step, step_tick, err}, time_count);
        end
        reset = 1'b0;
        model_time = '0;
        cyc();
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_ready: got %0b expected 1", cmd_ready); end
        repeat (10) cyc();
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_steps = 16'd0; cmd_abort = 1'b0;
        clear_done = '1;
        test_reset();
        test_clear(2'd1);
        test_run3();
        test_run0();
        test_clear(2'd2);
        test_abort();
        test_stuck_done();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
